// File: rtl/disp_pkg.sv
// Shared constants and the anode decode helper for the four-digit display scanner.
package disp_pkg;

   localparam int          NUM_DIGITS = 4;
   localparam int          DIGIT_W    = 4;
   localparam int          SEL_W      = 2;
   localparam logic [3:0]  AN_IDLE    = 4'b1111;

   // One-cold anode enable: the selected digit is driven low, all others idle high.
   function automatic logic [NUM_DIGITS-1:0] an_decode(input logic [SEL_W-1:0] sel);
      return AN_IDLE ^ (4'b0001 << sel);
   endfunction

endpackage

// File: rtl/disp_scan_prescaler.sv
// Free-running scan prescaler: tick is high for one clock out of every 2^DIV_W.
module scan_prescaler #(
   parameter int DIV_W = 17
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_ONE;
      end
   end

   assign tick = &div_cnt;

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed display scanner with double-buffered, frame-aligned updates.
// Optional leading-zero blanking is compiled in with macro DISP_LZB_EN.
module disp_scan
   import disp_pkg::*;
#(
   parameter int DIV_W = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] hexs,
   input  logic [3:0]  points,
   input  logic [3:0]  les,
   output logic [3:0]  AN,
   output logic [3:0]  HEX,
   output logic        point,
   output logic        LE,
   output logic        busy,
   output logic        ack
);

   logic             tick;
   logic             frame_end;
   logic             commit;
   logic [SEL_W-1:0] sel;
   logic             pending;
   logic             le_sel;

   logic [15:0]      stage_hexs;
   logic [3:0]       stage_points;
   logic [3:0]       stage_les;
   logic [15:0]      shadow_hexs;
   logic [3:0]       shadow_points;
   logic [3:0]       shadow_les;

   scan_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign frame_end = tick && (sel == 2'd3);
   assign commit    = frame_end && pending;
   assign busy      = pending;

   // Digit select advances once per scan tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel <= '0;
      end else if (tick) begin
         sel <= sel + 2'd1;
      end
   end

   // Staging capture and pending flag; a load coinciding with commit keeps pending set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_hexs   <= '0;
         stage_points <= '0;
         stage_les    <= '0;
         pending      <= 1'b0;
      end else begin
         if (load) begin
            stage_hexs   <= hexs;
            stage_points <= points;
            stage_les    <= les;
         end
         if (load) begin
            pending <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
      end
   end

   // Shadow copy only moves at a frame boundary, so a frame never mixes words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_hexs   <= '0;
         shadow_points <= '0;
         shadow_les    <= 4'hF;
         ack           <= 1'b0;
      end else begin
         ack <= commit;
         if (commit) begin
            shadow_hexs   <= stage_hexs;
            shadow_points <= stage_points;
            shadow_les    <= stage_les;
         end
      end
   end

`ifdef DISP_LZB_EN
   logic [NUM_DIGITS-1:0] zero_dig;
   logic [NUM_DIGITS-1:0] lzb;

   // A digit is forced blank when it and every more-significant digit are zero.
   always_comb begin
      zero_dig = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         zero_dig[i] = (shadow_hexs[i*DIGIT_W +: DIGIT_W] == '0);
      end
      lzb    = '0;
      lzb[3] = zero_dig[3];
      lzb[2] = zero_dig[2] & lzb[3];
      lzb[1] = zero_dig[1] & lzb[2];
      lzb[0] = 1'b0;
   end

   assign le_sel = shadow_les[sel] | lzb[sel];
`else
   assign le_sel = shadow_les[sel];
`endif

   // Output stage: registered decode of the current digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         AN    <= 4'b1110;
         HEX   <= '0;
         point <= 1'b0;
         LE    <= 1'b1;
      end else begin
         AN    <= an_decode(sel);
         HEX   <= shadow_hexs[{sel, 2'b00} +: DIGIT_W];
         point <= shadow_points[sel];
         LE    <= le_sel;
      end
   end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The block SHALL have parameter DIV_W, default 17, giving the prescaler width; a scan tick occurs once every 2^DIV_W clocks, which is 1.31 ms at 100 MHz.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: request to capture a new display word.
REQ-005 The block SHALL have port hexs, input, 16 bits: four hex digits; digit i is hexs[4i+3:4i].
REQ-006 The block SHALL have port points, input, 4 bits: per-digit decimal point, passed through unmodified.
REQ-007 The block SHALL have port les, input, 4 bits: per-digit blank request, where 1 means blank.
REQ-008 The block SHALL have port AN, output, 4 bits: active-low digit enable, exactly one bit low.
REQ-009 The block SHALL have port HEX, output, 4 bits: nibble for the downstream MyMC14495 D3..D0 inputs.
REQ-010 The block SHALL have port point, output, 1 bit: feeds the MyMC14495 point input.
REQ-011 The block SHALL have port LE, output, 1 bit: feeds the MyMC14495 LE input, where 1 blanks the digit.
REQ-012 The block SHALL have port busy, output, 1 bit: a captured word is pending commit.
REQ-013 The block SHALL have port ack, output, 1 bit: one-cycle pulse when a pending word is committed to the display.

Function
REQ-014 The prescaler div_cnt (DIV_W bits) SHALL increment every clock and wrap from all-ones to 0.
- tick = 1 exactly while div_cnt is all-ones.
REQ-015 The digit index sel (2 bits) SHALL increment on tick, wrapping 3->0.
- frame_end = tick and sel==3.
REQ-016 AN, HEX, point and LE SHALL be registered and SHALL reflect sel one clock after sel changes.
- AN = ~(4'b0001 << sel).
- HEX = shadow nibble sel.
- point = shadow_points[sel].
- LE = shadow_les[sel].
REQ-017 The staging capture rule is: load=1 on a clock edge copies hexs, points and les into staging registers and sets pending.
REQ-018 Repeated load while pending SHALL overwrite staging (latest wins) and SHALL produce no extra ack.
REQ-019 The commit rule is: on frame_end with pending=1, staging SHALL be copied to shadow and ack SHALL pulse for exactly one cycle.
- pending clears in that cycle unless load=1 in the same cycle.
REQ-020 Simultaneous load and frame_end: the commit uses the staging contents before the edge, the new data enters staging, pending stays 1, and ack pulses.
REQ-021 The shadow registers SHALL change only at frame_end, so no frame ever mixes old and new words.
REQ-022 busy SHALL equal pending.
REQ-023 frame_end with pending=0 SHALL leave shadow unchanged and keep ack low.

Reset
REQ-024 While rst=1, regardless of clk, the registers SHALL hold the following values:
- div_cnt=0, sel=0.
- staging=0, shadow_hexs=0, shadow_points=0, shadow_les=4'hF.
- pending=0, ack=0.
- AN=4'b1110, HEX=0, point=0, LE=1.
REQ-025 Reset mid-frame or mid-pending SHALL discard staging, clear pending, and start a new frame at digit 0 after release.

Configuration
REQ-026 With macro DISP_LZB_EN defined, leading-zero blanking SHALL apply:
- LE is forced to 1 for any digit i>0 where all shadow digits i..3 are 0.
- Digit 0 is never forced blank.
- Forced blanking is ORed with shadow_les.
REQ-027 Without DISP_LZB_EN, LE SHALL equal shadow_les[sel] only, and no zero-detect logic SHALL be present.

Structure
REQ-028 Package disp_pkg SHALL hold the following shared items:
- NUM_DIGITS=4.
- DIGIT_W=4.
- AN_IDLE=4'b1111.
- The AN one-cold decode function.
REQ-029 Sub-module scan_prescaler (parameter DIV_W; ports clk, rst, tick) SHALL implement the prescaler; the staging, commit and output logic SHALL reside in disp_scan.

Verification
REQ-030 The bench SHALL cover these directed scenarios (all with DIV_W=2):
- Reset: assert rst mid-cycle without clk -> AN=1110, LE=1, busy=0 immediately.
- Scan: load hexs=16'h1234 and run 2 frames -> AN steps 1110, 1101, 1011, 0111 every 4 clocks, with HEX 4, 3, 2, 1 respectively, after commit.
- Commit: load at sel=1 -> busy=1 until frame_end, ack high exactly 1 cycle, new value appears only from the next digit 0.
- Overwrite: load 16'hAAAA then 16'h5555 within one frame -> single ack, display shows 5555.
- Simultaneous: load 16'h0F0F exactly on frame_end with 16'h1111 pending -> 1111 displayed, busy stays 1, 0F0F commits at the next frame_end.
- LZB (DISP_LZB_EN), hexs=16'h0070, les=0 -> LE pattern across digits 0..3 = 0,0,1,1; without the macro -> 0,0,0,0.
